ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

EX/MEM pipeline register for the 5-stage 16-bit CPU, sitting between the execute stage and the memory slice it feeds (M, WB, flags, addr, wdata, PC, ALU result). It is a two-entry skid buffer with valid/ready handshakes on both sides, so a stalled memory stage never drops an instruction. It owns the zr/neg/ov flag state, with a speculative copy updated at accept and a committed copy updated at retire. Flush restores the speculative flags from the committed copy.

## Interface
- No parameters; datapath fixed at 16 bits, M at 3 bits, flags at 3 bits {zr,neg,ov}.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  register can accept this cycle
- ex_M  in  3  {SPToPC,MemWrite,MemRead}
- ex_WB  in  1  writeback enable
- ex_flags  in  3  flag values produced by ALU
- ex_flag_we  in  3  per-bit flag update enable
- ex_addr, ex_wdata, ex_PC, ex_ALU  in  16 each  memory address, store data, PC, ALU result
- flush  in  1  discard all held entries (branch redirect)
- mem_valid  out  1  head entry valid
- mem_ready  in  1  MEM consumes head entry
- M  out  3  head M, forced 0 when !mem_valid
- WB  out  1  head WB, forced 0 when !mem_valid
- flags  out  3  resolved flags of head entry
- addr, wdata, PC, ALU  out  16 each  head entry fields

## Operation
- Storage: main entry (drives outputs) and skid entry; each holds valid bit, M, WB, resolved flags, addr, wdata, PC, ALU.
- accept = ex_valid & ex_ready & !flush; retire = mem_valid & mem_ready.
- Resolved flags at accept: bit i = ex_flag_we[i] ? ex_flags[i] : spec_flags[i]; spec_flags <= resolved.
- At retire: commit_flags <= head resolved flags.
- Entry movement per cycle (no flush):
  - main empty: accept loads main.
  - main full, retire, skid empty: accept loads main, else main empties.
  - main full, retire, skid full: skid moves to main; accept impossible (ex_ready=0).
  - main full, no retire: accept loads skid.
- ex_ready = !skid_valid (registered state only; no combinational path from mem_ready).
- Flush: both valids cleared next cycle; EX transfer in that cycle dropped, no spec update from it; spec_flags <= commit_flags, where commit_flags includes a same-cycle retire.
- Bubble: M=3'b000, WB=0 whenever mem_valid=0, so no memory write, PC redirect or writeback from a stale entry; addr/wdata/PC/ALU/flags hold last value.
- Order preserved strictly FIFO; no entry duplicated or lost absent flush.

## Timing
- Reset (rst=0, async): both valids 0, mem_valid=0, ex_ready=1, M=0, WB=0, flags=0, addr/wdata/PC/ALU=0, spec_flags=commit_flags=0.
- Latency: accept in cycle n -> mem_valid and fields visible in cycle n+1.
- Throughput: one instruction per cycle while mem_ready=1.
- Backpressure: mem_ready low one cycle with continuous input -> skid fills, ex_ready low following cycle, recovers the cycle after skid drains.
- mem_valid, M, WB, fields stable while mem_valid & !mem_ready.
- Reset mid-operation: all entries and flags cleared immediately regardless of clk.

## Test plan
- Reset then stream ex_PC=0x0010,0x0012,0x0014 with mem_ready=1 -> PC outputs same order one cycle later, ex_ready stays 1.
- Two accepts with mem_ready=0 -> second lands in skid, ex_ready=0; raise mem_ready -> outputs 0x0010 then 0x0012, ex_ready=1 the cycle after skid drains.
- Accept flag_we=3'b100, flags=3'b100, then flag_we=3'b010, flags=3'b010 -> head flags 3'b100 then 3'b110.
- Flush with two entries held (neither retired), commit_flags=0 -> mem_valid=0, M=0, WB=0 next cycle; next accepted entry with flag_we=0 shows flags=3'b000.
- Flush in same cycle as retire of head with resolved flags 3'b001 and ex_valid=1 -> EX instruction dropped, spec=commit=3'b001.
- Assert rst low asynchronously between edges while both entries full -> mem_valid, ex_ready=1, all outputs 0 before next clk edge.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: two-entry skid buffer between execute and memory,
// owning the speculative and committed zr/neg/ov flag state.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [2:0]  ex_M,
  input  logic        ex_WB,
  input  logic [2:0]  ex_flags,
  input  logic [2:0]  ex_flag_we,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_wdata,
  input  logic [15:0] ex_PC,
  input  logic [15:0] ex_ALU,
  input  logic        flush,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [2:0]  M,
  output logic        WB,
  output logic [2:0]  flags,
  output logic [15:0] addr,
  output logic [15:0] wdata,
  output logic [15:0] PC,
  output logic [15:0] ALU
);

  typedef struct packed {
    logic [2:0]  m;
    logic        wb;
    logic [2:0]  fl;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pc;
    logic [15:0] alu;
  } ent_t;

  ent_t       main_q, main_d, skid_q, skid_d, in_ent;
  logic       main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [2:0] spec_q, spec_d, commit_q, commit_d, resolved;
  logic       accept, retire;

  assign ex_ready = !skid_vld_q;
  assign accept   = ex_valid & ex_ready & !flush;
  assign retire   = main_vld_q & mem_ready;
  assign resolved = (ex_flag_we & ex_flags) | (~ex_flag_we & spec_q);
  assign in_ent   = '{m: ex_M, wb: ex_WB, fl: resolved, addr: ex_addr,
                      wdata: ex_wdata, pc: ex_PC, alu: ex_ALU};

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    commit_d   = retire ? main_q.fl : commit_q;
    spec_d     = spec_q;
    if (flush) begin
      // Data regs keep their last contents so bubble outputs stay put.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      spec_d     = commit_d;
    end else begin
      if (accept) spec_d = resolved;
      if (!main_vld_q) begin
        if (accept) begin
          main_d     = in_ent;
          main_vld_d = 1'b1;
        end
      end else if (retire) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else if (accept) begin
          main_d = in_ent;
        end else begin
          main_vld_d = 1'b0;
        end
      end else if (accept) begin
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      spec_q     <= '0;
      commit_q   <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      spec_q     <= spec_d;
      commit_q   <= commit_d;
    end
  end

  // Control fields are squashed in bubbles so a stale entry has no side effects.
  assign mem_valid = main_vld_q;
  assign M         = main_vld_q ? main_q.m  : 3'b000;
  assign WB        = main_vld_q ? main_q.wb : 1'b0;
  assign flags     = main_q.fl;
  assign addr      = main_q.addr;
  assign wdata     = main_q.wdata;
  assign PC        = main_q.pc;
  assign ALU       = main_q.alu;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: driver keeps a FIFO flag model and pushes
// expected entries; a negedge monitor compares the head and pops on retire.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [2:0]  m;
    logic        wb;
    logic [2:0]  fl;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pc;
    logic [15:0] alu;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic [2:0]  ex_M = '0, ex_flags = '0, ex_flag_we = '0;
  logic        ex_WB = 1'b0;
  logic [15:0] ex_addr = '0, ex_wdata = '0, ex_PC = '0, ex_ALU = '0;
  logic        flush = 1'b0, mem_valid, mem_ready = 1'b0;
  logic [2:0]  M, flags;
  logic        WB;
  logic [15:0] addr, wdata, PC, ALU;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_M(ex_M), .ex_WB(ex_WB), .ex_flags(ex_flags), .ex_flag_we(ex_flag_we),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_PC(ex_PC), .ex_ALU(ex_ALU),
    .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .M(M), .WB(WB), .flags(flags), .addr(addr), .wdata(wdata), .PC(PC), .ALU(ALU)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  ent_t mdl_q[$];
  ent_t exp_q[$];
  logic [2:0] spec = '0, commit = '0;
  logic [70:0] last = '0;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] outs();
    return {M, WB, flags, addr, wdata, PC, ALU};
  endfunction

  // Monitor: head entry must match scoreboard front; bubbles hold last fields.
  always @(negedge clk) begin
    if (!rst) begin
      last = '0;
    end else begin
      chk("ex_ready", 71'(ex_ready), 71'(exp_q.size() < 2));
      if (exp_q.size() == 0) begin
        chk("bubble_valid", 71'(mem_valid), 71'(0));
        chk("bubble_fields", outs(), {4'b0000, last[66:0]});
      end else begin
        chk("head_valid", 71'(mem_valid), 71'(1));
        chk("head_fields", outs(), exp_q[0]);
        last = exp_q[0];
        if (mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Reference model: FIFO of at most two instructions plus two flag copies.
  task automatic model_edge();
    int   n = mdl_q.size();
    bit   ret = (n > 0) && mem_ready;
    bit   acc = ex_valid && (n < 2) && !flush;
    ent_t e, h;
    logic [2:0] res;
    res = (ex_flag_we & ex_flags) | (~ex_flag_we & spec);
    e = '{m: ex_M, wb: ex_WB, fl: res, addr: ex_addr, wdata: ex_wdata,
          pc: ex_PC, alu: ex_ALU};
    if (ret) begin
      h = mdl_q.pop_front();
      commit = h.fl;
    end
    if (flush) begin
      spec = commit;
      mdl_q.delete();
      exp_q.delete();
    end else if (acc) begin
      spec = res;
      mdl_q.push_back(e);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic set_in(input bit v, input logic [15:0] pc, input logic [2:0] we,
                        input logic [2:0] f, input bit mr, input bit fl);
    ex_valid = v; ex_PC = pc; ex_flag_we = we; ex_flags = f;
    mem_ready = mr; flush = fl;
    ex_M = 3'($urandom); ex_WB = 1'($urandom);
    ex_addr = 16'($urandom); ex_wdata = 16'($urandom); ex_ALU = 16'($urandom);
  endtask

  // Called mid-cycle so the clear is observed without any clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    mdl_q.delete(); exp_q.delete();
    spec = '0; commit = '0;
    #1;
    chk("rst_mem_valid", 71'(mem_valid), 71'(0));
    chk("rst_ex_ready", 71'(ex_ready), 71'(1));
    chk("rst_outputs", outs(), 71'(0));
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    do_reset();
    // Streaming at full throughput
    set_in(1, 16'h0010, 3'b000, 3'b000, 1, 0); cyc();
    set_in(1, 16'h0012, 3'b000, 3'b000, 1, 0); cyc();
    set_in(1, 16'h0014, 3'b000, 3'b000, 1, 0); cyc();
    set_in(0, 16'h0000, 3'b000, 3'b000, 1, 0); cyc(); cyc();
    // Backpressure into the skid, flag merging across entries
    set_in(1, 16'h0010, 3'b100, 3'b100, 0, 0); cyc();
    set_in(1, 16'h0012, 3'b010, 3'b010, 0, 0); cyc();
    set_in(1, 16'h0099, 3'b000, 3'b000, 0, 0); cyc();
    set_in(0, 16'h0000, 3'b000, 3'b000, 1, 0); cyc(); cyc(); cyc();
    // Flush with two entries held and nothing committed
    do_reset();
    set_in(1, 16'h0020, 3'b111, 3'b111, 0, 0); cyc();
    set_in(1, 16'h0022, 3'b111, 3'b101, 0, 0); cyc();
    set_in(1, 16'h0024, 3'b111, 3'b111, 0, 1); cyc();
    set_in(1, 16'h0026, 3'b000, 3'b000, 1, 0); cyc();
    set_in(0, 16'h0000, 3'b000, 3'b000, 1, 0); cyc(); cyc();
    // Flush coinciding with retire of head carrying flags 3'b001
    do_reset();
    set_in(1, 16'h0030, 3'b111, 3'b001, 0, 0); cyc();
    set_in(1, 16'h0032, 3'b111, 3'b110, 1, 1); cyc();
    set_in(1, 16'h0034, 3'b000, 3'b000, 1, 0); cyc();
    set_in(0, 16'h0000, 3'b000, 3'b000, 1, 0); cyc(); cyc();
    // Asynchronous reset while both entries are full
    set_in(1, 16'h0040, 3'b011, 3'b011, 0, 0); cyc();
    set_in(1, 16'h0042, 3'b100, 3'b100, 0, 0); cyc();
    set_in(0, 16'h0000, 3'b000, 3'b000, 0, 0);
    do_reset();
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom), 3'($urandom),
             $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
      cyc();
    end
    set_in(0, 16'h0000, 3'b000, 3'b000, 1, 0); cyc(); cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
